// File: rtl/airi5c_dmem_bram_ctrl_if.sv
// AHB-Lite (HASTI) data-memory bus between the core's dmem master and the BRAM controller.
interface airi5c_dmem_bram_ctrl_if;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic        hmastlock;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic [31:0] hwdata;
   logic [31:0] hrdata;
   logic        hready;
   logic        hresp;

   modport master (
      output haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
      input  hrdata, hready, hresp
   );

   modport slave (
      input  haddr, hwrite, hsize, hburst, hmastlock, hprot, htrans, hwdata,
      output hrdata, hready, hresp
   );
endinterface

// File: rtl/airi5c_dmem_bram_ctrl.sv
// AHB-Lite slave bridging the core data port to one port of a synchronous single-port BRAM.
//
// state | meaning
// IDLE  | no data phase pending
// RD    | read data phase, BRAM output returned on hrdata
// WR    | write data phase, BRAM written this cycle; stalls a following read
// WRH   | write done after a stall, held read address issued to the BRAM
// ERR1  | first ERROR cycle (hready low)
// ERR2  | second ERROR cycle (hready high, next transfer accepted)
module airi5c_dmem_bram_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter logic [31:0] BASE_MASK = 32'hC000_0000,
   parameter int          MEM_AW    = 19
) (
   input  logic                  clk,
   input  logic                  reset,
   airi5c_dmem_bram_ctrl_if.slave bus,
   output logic                  bram_en,
   output logic [3:0]            bram_we,
   output logic [MEM_AW-1:0]     bram_addr,
   output logic [31:0]           bram_wdata,
   input  logic [31:0]           bram_rdata
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_WRH  = 3'd3,
      S_ERR1 = 3'd4,
      S_ERR2 = 3'd5
   } st_t;

   st_t               st, st_nxt;
   logic [MEM_AW-1:0] addr_q;
   logic [3:0]        mask_q;

   logic              trans_act;
   logic              bad;
   logic              rd_req;
   logic              accept;
   logic [3:0]        mask;
   logic              rdy;
   logic              resp;
   logic [31:0]       rdata;

   always_comb begin
      trans_act = bus.htrans[1];
      bad = ((bus.haddr & BASE_MASK) != BASE_ADDR)
         || (bus.hsize > 3'd2)
         || ((bus.hsize == 3'd1) && bus.haddr[0])
         || ((bus.hsize == 3'd2) && (bus.haddr[1:0] != 2'b00));
      rd_req = trans_act && !bus.hwrite && !bad;
      case (bus.hsize)
         3'd0:    mask = 4'b0001 << bus.haddr[1:0];
         3'd1:    mask = 4'b0011 << bus.haddr[1:0];
         default: mask = 4'b1111;
      endcase
   end

   always_comb begin
      rdy        = 1'b1;
      resp       = 1'b0;
      rdata      = 32'h0;
      bram_en    = 1'b0;
      bram_we    = 4'b0000;
      bram_addr  = bus.haddr[MEM_AW+1:2];
      bram_wdata = bus.hwdata;
      st_nxt     = st;

      case (st)
         S_RD: rdata = bram_rdata;
         S_WR: begin
            bram_en   = 1'b1;
            bram_we   = mask_q;
            bram_addr = addr_q;
            // The port is busy with the write, so a read must wait one cycle.
            if (rd_req) rdy = 1'b0;
         end
         S_ERR1: begin
            rdy  = 1'b0;
            resp = 1'b1;
         end
         S_ERR2: resp = 1'b1;
         default: ;
      endcase

      accept = rdy && trans_act;
      if (accept && rd_req) bram_en = 1'b1;

      if (st == S_ERR1)  st_nxt = S_ERR2;
      else if (!rdy)     st_nxt = S_WRH;
      else if (!accept)  st_nxt = S_IDLE;
      else if (bad)      st_nxt = S_ERR1;
      else if (bus.hwrite) st_nxt = S_WR;
      else               st_nxt = S_RD;
   end

   assign bus.hready = rdy;
   assign bus.hresp  = resp;
   assign bus.hrdata = rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= S_IDLE;
         addr_q <= '0;
         mask_q <= 4'b0000;
      end else begin
         st <= st_nxt;
         if (accept && !bad) begin
            addr_q <= bus.haddr[MEM_AW+1:2];
            mask_q <= mask;
         end
      end
   end

endmodule

// File: tb/tb_airi5c_dmem_bram_ctrl.sv
// Directed bench for the dmem BRAM controller with a BRAM model and a data-phase scoreboard.
module tb_airi5c_dmem_bram_ctrl;

   localparam int K_RD  = 0;
   localparam int K_WR  = 1;
   localparam int K_ERR = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        bram_en;
   logic [3:0]  bram_we;
   logic [18:0] bram_addr;
   logic [31:0] bram_wdata;
   logic [31:0] bram_rdata;

   logic [31:0] mem     [0:1023];
   logic [31:0] ref_mem [0:1023];
   logic        pl_en = 1'b0;
   logic [9:0]  pl_idx;
   logic [31:0] pl_data;

   typedef struct {
      int          kind;
      logic [31:0] data;
      logic [3:0]  mask;
      logic [31:0] waddr;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   w;

   airi5c_dmem_bram_ctrl_if bus ();

   airi5c_dmem_bram_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .bus        (bus),
      .bram_en    (bram_en),
      .bram_we    (bram_we),
      .bram_addr  (bram_addr),
      .bram_wdata (bram_wdata),
      .bram_rdata (bram_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_en) mem[pl_idx] <= pl_data;
      else if (bram_en) begin
         for (int i = 0; i < 4; i++)
            if (bram_we[i]) mem[bram_addr[9:0]][8*i +: 8] <= bram_wdata[8*i +: 8];
         bram_rdata <= mem[bram_addr[9:0]];
      end
   end

   function automatic logic exp_err(input logic [31:0] a, input logic [2:0] sz);
      return ((a & 32'hC000_0000) != 32'h8000_0000) || (sz > 3'd2)
         || ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
   endfunction

   function automatic logic [3:0] exp_mask(input logic [31:0] a, input logic [2:0] sz);
      case (sz)
         3'd0:    return 4'b0001 << a[1:0];
         3'd1:    return 4'b0011 << a[1:0];
         default: return 4'b1111;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check the data phase of the oldest accepted transfer in the current cycle.
   task automatic check_dp(input logic exp_stall);
      if (exp_q.size() == 0) begin
         chk("idle_hrdata", bus.hrdata, 32'h0);
         chk("idle_hresp", 32'(bus.hresp), 32'h0);
         return;
      end
      case (exp_q[0].kind)
         K_RD: begin
            chk("rd_hready", 32'(bus.hready), 32'h1);
            chk("rd_data", bus.hrdata, exp_q[0].data);
            chk("rd_hresp", 32'(bus.hresp), 32'h0);
            void'(exp_q.pop_front());
         end
         K_WR: begin
            if (exp_q[0].cyc == 0) begin
               chk("wr_we", 32'(bram_we), 32'(exp_q[0].mask));
               chk("wr_en", 32'(bram_en), 32'h1);
               chk("wr_addr", 32'(bram_addr), exp_q[0].waddr);
               chk("wr_wdata", bram_wdata, exp_q[0].data);
               chk("wr_hready", 32'(bus.hready), 32'(!exp_stall));
               chk("wr_hresp", 32'(bus.hresp), 32'h0);
               if (bus.hready) void'(exp_q.pop_front());
               else exp_q[0].cyc = 1;
            end else begin
               chk("wrh_hready", 32'(bus.hready), 32'h1);
               chk("wrh_we", 32'(bram_we), 32'h0);
               void'(exp_q.pop_front());
            end
         end
         default: begin
            if (exp_q[0].cyc == 0) begin
               chk("err1_hready", 32'(bus.hready), 32'h0);
               chk("err1_hresp", 32'(bus.hresp), 32'h1);
               chk("err1_en", 32'(bram_en), 32'h0);
               exp_q[0].cyc = 1;
            end else begin
               chk("err2_hready", 32'(bus.hready), 32'h1);
               chk("err2_hresp", 32'(bus.hresp), 32'h1);
               void'(exp_q.pop_front());
            end
         end
      endcase
   endtask

   // Present one address phase and hold it until accepted; waits returns stall cycles.
   task automatic step(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                       input logic [2:0] sz, input logic [31:0] wd, output int waits);
      logic done, e_err, stall, port_busy;
      exp_t e;
      bus.htrans = tr;
      bus.hwrite = wr;
      bus.haddr  = a;
      bus.hsize  = sz;
      e_err = exp_err(a, sz);
      stall = tr[1] && !wr && !e_err;
      waits = 0;
      done  = 1'b0;
      port_busy = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         port_busy = (exp_q.size() > 0) && (exp_q[0].kind == K_WR) && (exp_q[0].cyc == 0);
         check_dp(stall);
         if (bus.hready) begin
            done = 1'b1;
            break;
         end
         waits++;
         @(posedge clk);
         #1;
      end
      if (!done) chk("accept_timeout", 32'h0, 32'h1);
      if (done && tr[1]) begin
         if (!port_busy) begin
            if (e_err) chk("err_no_en", 32'(bram_en), 32'h0);
            else if (!wr) begin
               chk("rd_issue_en", 32'(bram_en), 32'h1);
               chk("rd_issue_addr", 32'(bram_addr), {13'h0, a[20:2]});
               chk("rd_issue_we", 32'(bram_we), 32'h0);
            end
         end
         e.cyc   = 0;
         e.mask  = exp_mask(a, sz);
         e.waddr = {13'h0, a[20:2]};
         e.data  = wd;
         if (e_err) e.kind = K_ERR;
         else if (wr) begin
            e.kind = K_WR;
            for (int i = 0; i < 4; i++)
               if (e.mask[i]) ref_mem[a[11:2]][8*i +: 8] = wd[8*i +: 8];
         end else begin
            e.kind = K_RD;
            e.data = ref_mem[a[11:2]];
         end
         exp_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (done && tr[1] && wr && !e_err) bus.hwdata = wd;
   endtask

   task automatic flush();
      int fw;
      for (int n = 0; n < 6 && exp_q.size() > 0; n++) step(2'd0, 1'b0, 32'h0, 3'd2, 32'h0, fw);
      if (exp_q.size() > 0) begin
         chk("flush_timeout", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
      end
   endtask

   task automatic preload(input logic [9:0] idx, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_idx  = idx;
      pl_data = d;
      @(posedge clk);
      #1;
      pl_en = 1'b0;
      ref_mem[idx] = d;
   endtask

   initial begin
      bus.hburst    = 3'd0;
      bus.hmastlock = 1'b0;
      bus.hprot     = 4'd0;
      reset = 1'b1;
      for (int c = 0; c < 2; c++) begin
         bus.haddr  = $urandom;
         bus.htrans = 2'($urandom_range(0, 3));
         bus.hwrite = 1'($urandom_range(0, 1));
         bus.hsize  = 3'($urandom_range(0, 7));
         bus.hwdata = $urandom;
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      bus.htrans = 2'd0;
      bus.hwrite = 1'b0;
      bus.haddr  = 32'h0;
      bus.hsize  = 3'd2;
      @(negedge clk);
      chk("rst_hready", 32'(bus.hready), 32'h1);
      chk("rst_hresp", 32'(bus.hresp), 32'h0);
      chk("rst_en", 32'(bram_en), 32'h0);
      chk("rst_we", 32'(bram_we), 32'h0);
      chk("rst_hrdata", bus.hrdata, 32'h0);
      @(posedge clk);
      #1;

      // Word write immediately followed by a read of the same word.
      step(2'd2, 1'b1, 32'h8000_0010, 3'd2, 32'hDEAD_BEEF, w);
      step(2'd2, 1'b0, 32'h8000_0010, 3'd2, 32'h0, w);
      chk("wr_rd_stall_waits", 32'(w), 32'h1);
      flush();

      // Byte write into the top lane of a preloaded word.
      preload(10'd4, 32'h1122_3344);
      step(2'd2, 1'b1, 32'h8000_0013, 3'd0, 32'hAB00_0000, w);
      step(2'd2, 1'b0, 32'h8000_0010, 3'd2, 32'h0, w);
      flush();

      // Half-word write on the upper half, then write->write with no wait.
      step(2'd2, 1'b1, 32'h8000_0032, 3'd1, 32'h5A5A_0000, w);
      step(2'd2, 1'b1, 32'h8000_0034, 3'd2, 32'h0BAD_F00D, w);
      chk("wr_wr_waits", 32'(w), 32'h0);
      step(2'd0, 1'b0, 32'h0, 3'd2, 32'h0, w);
      step(2'd2, 1'b0, 32'h8000_0034, 3'd2, 32'h0, w);
      flush();

      // Misaligned half-word read, then an aligned read.
      preload(10'd0, 32'hCAFE_0001);
      step(2'd2, 1'b0, 32'h8000_0001, 3'd1, 32'h0, w);
      step(2'd2, 1'b0, 32'h8000_0000, 3'd2, 32'h0, w);
      chk("err_accept_waits", 32'(w), 32'h1);
      flush();

      // Unmapped and oversized writes leave the RAM untouched.
      step(2'd2, 1'b1, 32'h0000_1000, 3'd2, 32'h1111_1111, w);
      bus.hwdata = 32'h1111_1111;
      step(2'd2, 1'b1, 32'h8000_0000, 3'd3, 32'h2222_2222, w);
      bus.hwdata = 32'h2222_2222;
      step(2'd2, 1'b0, 32'h8000_0000, 3'd2, 32'h0, w);
      flush();

      // Four back-to-back reads.
      for (int i = 0; i < 4; i++) preload(10'(8 + i), 32'h7000_0000 + 32'(i * 16 + 3));
      for (int i = 0; i < 4; i++) begin
         step((i == 0) ? 2'd2 : 2'd3, 1'b0, 32'h8000_0020 + 32'(4 * i), 3'd2, 32'h0, w);
         chk("b2b_waits", 32'(w), 32'h0);
      end
      flush();

      // Reset asserted during the write->read stall cycle.
      step(2'd2, 1'b1, 32'h8000_0040, 3'd2, 32'h1234_5678, w);
      bus.htrans = 2'd2;
      bus.hwrite = 1'b0;
      bus.haddr  = 32'h8000_0044;
      bus.hsize  = 3'd2;
      @(negedge clk);
      chk("rst_stall_hready", 32'(bus.hready), 32'h0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      bus.htrans = 2'd0;
      exp_q.delete();
      @(negedge clk);
      chk("rst_mid_st", 32'(dut.st), 32'h0);
      chk("rst_mid_hready", 32'(bus.hready), 32'h1);
      chk("rst_mid_en", 32'(bram_en), 32'h0);
      chk("rst_mid_hresp", 32'(bus.hresp), 32'h0);
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
